// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, helpers and types for the pipeline width converters.
package pipe_pkg;
   localparam int DEF_IN_DWIDTH  = 8;
   localparam int DEF_RATIO      = 4;
   localparam int DEF_OUT_DWIDTH = DEF_IN_DWIDTH * DEF_RATIO;
   typedef logic [DEF_RATIO-1:0] keep_t;
   // $clog2(2) is 1 but $clog2(1) is 0, so clamp to keep a real counter bit.
   function automatic int cnt_width(input int ratio);
      return (ratio <= 2) ? 1 : $clog2(ratio);
   endfunction
   function automatic int out_dwidth(input int in_dwidth, input int ratio);
      return in_dwidth * ratio;
   endfunction
endpackage

// File: rtl/pipe_width_packer.sv
// pipe_width_packer: packs RATIO narrow beats into one wide word; i_last closes a partial word.
module pipe_width_packer
   import pipe_pkg::*;
#(
   parameter int IN_DWIDTH  = DEF_IN_DWIDTH,
   parameter int RATIO      = DEF_RATIO,
   parameter int OUT_DWIDTH = out_dwidth(IN_DWIDTH, RATIO)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [IN_DWIDTH-1:0]  i_data,
   input  logic                  i_valid,
   input  logic                  i_last,
   output logic                  o_ready,
   output logic [OUT_DWIDTH-1:0] o_data,
   output logic [RATIO-1:0]      o_keep,
   output logic                  o_last,
   output logic                  o_valid,
   input  logic                  i_ready
);
   localparam int             CW      = cnt_width(RATIO);
   localparam logic [CW-1:0]  CNT_MAX = CW'(RATIO - 1);

   logic [OUT_DWIDTH-1:0] acc_rg, acc_d, data_rg, data_d, merged_data;
   logic [RATIO-1:0]      kacc_rg, kacc_d, keep_rg, keep_d, merged_keep;
   logic [CW-1:0]         cnt_rg, cnt_d;
   logic                  last_rg, last_d, valid_rg, valid_d;
   logic                  acc_in, acc_out, completing;

   assign o_ready    = ~valid_rg | i_ready;
   assign acc_in     = i_valid & o_ready;
   assign acc_out    = valid_rg & i_ready;
   assign completing = (cnt_rg == CNT_MAX) | i_last;
   assign o_data     = data_rg;
   assign o_keep     = keep_rg;
   assign o_last     = last_rg;
   assign o_valid    = valid_rg;

   always_comb begin
      merged_data = acc_rg;
      merged_keep = kacc_rg;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt_rg == CW'(k)) begin
            merged_data[k*IN_DWIDTH +: IN_DWIDTH] = i_data;
            merged_keep[k] = 1'b1;
         end
      end
      acc_d   = acc_rg;
      kacc_d  = kacc_rg;
      cnt_d   = cnt_rg;
      data_d  = data_rg;
      keep_d  = keep_rg;
      last_d  = last_rg;
      valid_d = acc_out ? 1'b0 : valid_rg;
      if (acc_in && completing) begin
         data_d  = merged_data;
         keep_d  = merged_keep;
         last_d  = i_last;
         valid_d = 1'b1;
         acc_d   = '0;
         kacc_d  = '0;
         cnt_d   = '0;
      end else if (acc_in) begin
         acc_d  = merged_data;
         kacc_d = merged_keep;
         cnt_d  = cnt_rg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc_rg   <= '0;
         kacc_rg  <= '0;
         cnt_rg   <= '0;
         data_rg  <= '0;
         keep_rg  <= '0;
         last_rg  <= 1'b0;
         valid_rg <= 1'b0;
      end else begin
         acc_rg   <= acc_d;
         kacc_rg  <= kacc_d;
         cnt_rg   <= cnt_d;
         data_rg  <= data_d;
         keep_rg  <= keep_d;
         last_rg  <= last_d;
         valid_rg <= valid_d;
      end
   end
endmodule

// File: tb/tb_pipe_width_packer.sv
// tb_pipe_width_packer: directed and random stimulus against a queue-based packet model.
module tb_pipe_width_packer;
   localparam int IW = 8;
   localparam int R  = 4;
   localparam int OW = IW * R;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [IW-1:0] i_data = '0;
   logic          i_valid = 1'b0;
   logic          i_last = 1'b0;
   logic          i_ready = 1'b1;
   logic          o_ready, o_last, o_valid;
   logic [OW-1:0] o_data;
   logic [R-1:0]  o_keep;

   int n_chk = 0;
   int n_fail = 0;

   logic [IW-1:0] cur[$];
   logic [OW-1:0] q_data[$];
   logic [R-1:0]  q_keep[$];
   logic          q_last[$];

   pipe_width_packer #(.IN_DWIDTH(IW), .RATIO(R)) dut (
      .clk(clk), .rstn(rstn), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
      .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last),
      .o_valid(o_valid), .i_ready(i_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at negedge, sample settled outputs, then advance the model.
   task automatic cycle(input bit v, input logic [IW-1:0] d, input bit l, input bit r);
      logic [OW-1:0] w;
      @(negedge clk);
      i_valid = v;
      i_data  = d;
      i_last  = l;
      i_ready = r;
      #1;
      check("ready_rule", OW'(o_ready), OW'(!o_valid || i_ready));
      if (q_data.size() != 0) begin
         check("valid", OW'(o_valid), OW'(1));
         check("data", o_data, q_data[0]);
         check("keep", OW'(o_keep), OW'(q_keep[0]));
         check("last", OW'(o_last), OW'(q_last[0]));
         if (o_valid && i_ready) begin
            void'(q_data.pop_front());
            void'(q_keep.pop_front());
            void'(q_last.pop_front());
         end
      end else begin
         check("valid_idle", OW'(o_valid), OW'(0));
      end
      if (i_valid && o_ready) begin
         cur.push_back(d);
         if (cur.size() == R || l) begin
            w = '0;
            foreach (cur[k]) w = w | (OW'(cur[k]) << (IW * k));
            q_data.push_back(w);
            q_keep.push_back(R'((1 << cur.size()) - 1));
            q_last.push_back(l);
            cur.delete();
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn    = 1'b0;
      i_valid = 1'b1;
      i_data  = 8'hEE;
      i_ready = 1'($urandom_range(0, 1));
      cur.delete();
      q_data.delete();
      q_keep.delete();
      q_last.delete();
      @(negedge clk);
      #1;
      check("rst_ready", OW'(o_ready), OW'(1));
      check("rst_valid", OW'(o_valid), OW'(0));
      @(negedge clk);
      rstn    = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      #1;
      check("post_rst_valid", OW'(o_valid), OW'(0));
      check("post_rst_data", o_data, '0);
      check("post_rst_keep", OW'(o_keep), OW'(0));
      check("post_rst_last", OW'(o_last), OW'(0));
      check("post_rst_ready", OW'(o_ready), OW'(1));
   endtask

   initial begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1, IW'(8'h11 * (i + 1)), 0, 1);
         check("t1_ready", OW'(o_ready), OW'(1));
      end
      cycle(0, 0, 0, 1);
      check("t1_word", o_data, 32'h44332211);
      cycle(0, 0, 0, 1);
      check("t1_one_cycle", OW'(o_valid), OW'(0));
      cycle(1, 8'hA1, 0, 1);
      cycle(1, 8'hA2, 1, 1);
      cycle(0, 0, 0, 1);
      check("t2_word", o_data, 32'h0000A2A1);
      check("t2_keep", OW'(o_keep), OW'(4'b0011));
      cycle(1, 8'h5C, 1, 1);
      cycle(0, 0, 0, 1);
      check("t3_word", o_data, 32'h0000005C);
      check("t3_keep", OW'(o_keep), OW'(4'b0001));
      check("t3_last", OW'(o_last), OW'(1));
      for (int i = 0; i < 4; i++) cycle(1, IW'(8'h11 * (i + 1)), 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 8'h99, 0, 0);
         check("t4_stall_ready", OW'(o_ready), OW'(0));
         check("t4_held", o_data, 32'h44332211);
      end
      cycle(1, 8'h99, 1, 1);
      check("t4_release_ready", OW'(o_ready), OW'(1));
      cycle(0, 0, 0, 1);
      check("t4_next", o_data, 32'h00000099);
      for (int i = 1; i <= 8; i++) begin
         cycle(1, IW'(i), 0, 1);
         check("t5_no_stall", OW'(o_ready), OW'(1));
         if (i == 5) check("t5_first", o_data, 32'h04030201);
      end
      cycle(0, 0, 0, 1);
      check("t5_second", o_data, 32'h08070605);
      cycle(1, 8'h11, 0, 1);
      cycle(1, 8'h22, 0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, IW'(8'h55 + i), 0, 1);
      cycle(0, 0, 0, 1);
      check("t6_post_rst_word", o_data, 32'h58575655);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         else cycle($urandom_range(0, 9) < 7, IW'($urandom), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) < 6);
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
